// File: rtl/serv_ibus_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : serv_ibus_fifo
//  Description : Prefetch word FIFO (DEPTH x 32) with push, pop, flush and
//                an occupancy count. Flush wins over push/pop in a cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module serv_ibus_fifo #(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       i_rst,
    input  logic                       i_push,
    input  logic [31:0]                i_wdata,
    input  logic                       i_pop,
    input  logic                       i_flush,
    output logic [31:0]                o_rdata,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);
    localparam int              c_AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int              c_CW    = $clog2(DEPTH + 1);
    localparam logic [c_AW-1:0] c_LAST  = c_AW'(DEPTH - 1);
    localparam logic [c_CW-1:0] c_FULL  = c_CW'(DEPTH);

    logic [31:0]     r_mem [DEPTH];
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_CW-1:0] r_count;
    logic            w_do_push;
    logic            w_do_pop;

    // Pointers wrap explicitly so non-power-of-two storage indices never escape.
    function automatic logic [c_AW-1:0] f_inc(input logic [c_AW-1:0] p);
        return (p == c_LAST) ? '0 : p + c_AW'(1);
    endfunction

    // Guard the invariants: never write when full, never read when empty.
    assign w_do_push = i_push && (r_count != c_FULL);
    assign w_do_pop  = i_pop  && (r_count != '0);

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (i_rst || i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= f_inc(r_wr_ptr);
            if (w_do_pop)  r_rd_ptr <= f_inc(r_rd_ptr);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + c_CW'(1);
                2'b01:   r_count <= r_count - c_CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Word storage; contents are don't-care while the count says empty.
    always_ff @(posedge clk) begin
        if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_wdata;
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/serv_ibus_prefetch.sv
`default_nettype none
// ============================================================================
//  Module      : serv_ibus_prefetch
//  Description : Instruction fetch stage between the CPU ibus and a Wishbone
//                classic memory bus. Serves sequential code from a small
//                prefetch FIFO and feeds serv_decode's rdt/en pair.
//  Revision    : 1.0 - initial release
// ============================================================================
module serv_ibus_prefetch #(
    parameter int DEPTH   = 2,
    parameter bit PREF_EN = 1'b1
) (
    input  logic        clk,
    input  logic        i_rst,
    input  logic        i_cpu_cyc,
    input  logic [31:0] i_cpu_adr,
    output logic [31:0] o_cpu_rdt,
    output logic        o_cpu_ack,
    output logic [29:0] o_dec_rdt,
    output logic        o_dec_en,
    output logic        o_mem_cyc,
    output logic [31:0] o_mem_adr,
    input  logic [31:0] i_mem_rdt,
    input  logic        i_mem_ack
);
    localparam int         c_CW      = $clog2(DEPTH + 1);
    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_DEMAND  = 2'd1;
    localparam logic [1:0] c_PREF    = 2'd2;
    localparam logic [1:0] c_DISCARD = 2'd3;

    // Addresses are kept as word addresses; bits [1:0] are implicitly zero.
    logic [1:0]      r_state,     w_state;
    logic [29:0]     r_fetch_adr, w_fetch_adr;
    logic [29:0]     r_head_adr,  w_head_adr;
    logic [29:0]     r_mem_adr,   w_mem_adr;
    logic            r_mem_cyc,   w_mem_cyc;
    logic            r_ack,       w_ack;
    logic [31:0]     r_rdt,       w_rdt;
    logic            r_live,      w_live;

    logic [29:0]     w_cpu_word;
    logic [1:0]      w_unused_adr_lsb;
    logic [c_CW-1:0] w_count;
    logic [c_CW:0]   w_next_cnt;
    logic [31:0]     w_head_data;
    logic            w_mem_ack, w_req, w_hit, w_wait, w_miss;
    logic            w_push, w_pop, w_room;

    assign w_cpu_word       = i_cpu_adr[31:2];
    assign w_unused_adr_lsb = i_cpu_adr[1:0];

    // An ack with no cycle open (e.g. straggling across reset) is ignored.
    assign w_mem_ack = i_mem_ack && r_mem_cyc;

    // Requests are looked at only in states that can act on them, and never
    // in the cycle that is already returning an ack.
    assign w_req  = i_cpu_cyc && !r_ack && ((r_state == c_IDLE) || (r_state == c_PREF));
    assign w_hit  = w_req && (w_count != '0) && (w_cpu_word == r_head_adr);
    // Word being prefetched right now is the one wanted: let it land, then hit.
    assign w_wait = w_req && (r_state == c_PREF) && (w_count == '0) && (w_cpu_word == r_fetch_adr);
    assign w_miss = w_req && !w_hit && !w_wait;

    assign w_pop      = w_hit;
    assign w_push     = (r_state == c_PREF) && w_mem_ack && !w_miss;
    assign w_next_cnt = {1'b0, w_count} + {{c_CW{1'b0}}, w_push} - {{c_CW{1'b0}}, w_pop};
    assign w_room     = w_next_cnt < (c_CW + 1)'(DEPTH);

    serv_ibus_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .i_rst   (i_rst),
        .i_push  (w_push),
        .i_wdata (i_mem_rdt),
        .i_pop   (w_pop),
        .i_flush (w_miss),
        .o_rdata (w_head_data),
        .o_count (w_count)
    );

    // Next-state, bus-cycle and response decisions.
    always_comb begin
        w_state     = r_state;
        w_fetch_adr = r_fetch_adr;
        w_head_adr  = w_hit ? r_head_adr + 30'd1 : r_head_adr;
        w_mem_cyc   = r_mem_cyc;
        w_mem_adr   = r_mem_adr;
        w_ack       = w_hit;
        w_rdt       = w_hit ? w_head_data : r_rdt;
        w_live      = r_live;

        case (r_state)
            c_IDLE: begin
                if (w_miss) begin
                    w_fetch_adr = w_cpu_word;
                    w_state     = c_DEMAND;
                    w_mem_cyc   = 1'b1;
                    w_mem_adr   = w_cpu_word;
                end else if (PREF_EN && r_live && w_room) begin
                    // Only speculate once a demand fetch has set up a stream.
                    w_state   = c_PREF;
                    w_mem_cyc = 1'b1;
                    w_mem_adr = r_fetch_adr;
                end
            end
            c_DEMAND: begin
                if (!r_mem_cyc) begin
                    w_mem_cyc = 1'b1;
                    w_mem_adr = r_fetch_adr;
                end else if (w_mem_ack) begin
                    w_mem_cyc   = 1'b0;
                    w_rdt       = i_mem_rdt;
                    w_ack       = 1'b1;
                    w_head_adr  = r_fetch_adr + 30'd1;
                    w_fetch_adr = r_fetch_adr + 30'd1;
                    w_live      = 1'b1;
                    w_state     = PREF_EN ? c_PREF : c_IDLE;
                end
            end
            c_PREF: begin
                if (w_miss) begin
                    w_fetch_adr = w_cpu_word;
                    if (r_mem_cyc && !w_mem_ack) begin
                        // Classic cycles cannot be aborted; ride this one out.
                        w_state = c_DISCARD;
                    end else begin
                        w_state = c_DEMAND;
                        if (r_mem_cyc) begin
                            w_mem_cyc = 1'b0;
                        end else begin
                            w_mem_cyc = 1'b1;
                            w_mem_adr = w_cpu_word;
                        end
                    end
                end else if (r_mem_cyc) begin
                    if (w_mem_ack) begin
                        w_mem_cyc   = 1'b0;
                        w_fetch_adr = r_fetch_adr + 30'd1;
                        if (!w_room) w_state = c_IDLE;
                    end
                end else if (w_room) begin
                    w_mem_cyc = 1'b1;
                    w_mem_adr = r_fetch_adr;
                end else begin
                    w_state = c_IDLE;
                end
            end
            default: begin
                if (w_mem_ack) begin
                    w_mem_cyc = 1'b0;
                    w_state   = c_DEMAND;
                end
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_state     <= c_IDLE;
            r_fetch_adr <= '0;
            r_head_adr  <= '0;
            r_mem_adr   <= '0;
            r_mem_cyc   <= 1'b0;
            r_ack       <= 1'b0;
            r_rdt       <= '0;
            r_live      <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_fetch_adr <= w_fetch_adr;
            r_head_adr  <= w_head_adr;
            r_mem_adr   <= w_mem_adr;
            r_mem_cyc   <= w_mem_cyc;
            r_ack       <= w_ack;
            r_rdt       <= w_rdt;
            r_live      <= w_live;
        end
    end

    assign o_cpu_rdt = r_rdt;
    assign o_cpu_ack = r_ack;
    assign o_dec_rdt = r_rdt[31:2];
    assign o_dec_en  = r_ack;
    assign o_mem_cyc = r_mem_cyc;
    assign o_mem_adr = {r_mem_adr, 2'b00};

endmodule
`default_nettype wire
